vga_scanout: RTL and testbench

Parametrised VGA scan-out engine: the successor to the fixed 640x480, 2-bit-per-channel VGA driver. It takes a streamed pixel word per active pixel over the stb/ack handshake used by the pixel processor, buffers it in an internal FIFO, and generates registered RGB, hsync, vsync, de and screen coordinates for any timing set. New over the previous driver: parametrised geometry, colour depth and sync polarity, a prefill/run state machine, underflow substitution and counting, and a frame-start pulse.

---
 rtl/vga_scanout.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA scan-out engine.
//
// Pixel words arrive over a stb/ack handshake and are buffered in a small
// FIFO. A prefill/run state machine starts the raster once enough words are
// queued, then one word is popped per active pixel. Colour, syncs, de and the
// screen coordinates are all registered and mutually aligned.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous active-low reset
//   enable         scan-out enable (0 returns to IDLE, flushing the FIFO)
//   sync           restart frame: flush FIFO, zero counters, back to PREFILL
//   pix_data       input word {r,g,b}, r in the MSBs
//   pix_stb        input word valid
//   pix_ack        combinational ready (rst && !full)
//   vga_r/g/b      registered colour
//   hsync, vsync   registered syncs, polarity set by SYNC_POL
//   de             registered data enable
//   sx, sy         registered coordinates of the pixel on the outputs
//   frame_start    one-cycle pulse while (0,0) is on the outputs
//   fifo_level     FIFO occupancy
//   underflow_cnt  saturating count of active pixels shown without data
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | scan-out off, counters at 0, outputs blank, FIFO accepts
// PREFILL  | waiting for PREFILL words, counters at 0, outputs blank
// RUN      | counters advance every cycle, outputs follow the raster
module vga_scanout #(
  parameter int unsigned COLOR_BITS = 2,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned COORD_BITS = 10,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PREFILL    = FIFO_DEPTH / 2,
  parameter logic [3*COLOR_BITS-1:0] UNDERFLOW_COLOR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sync,
  input  logic [3*COLOR_BITS-1:0]       pix_data,
  input  logic                          pix_stb,
  output logic                          pix_ack,
  output logic [COLOR_BITS-1:0]         vga_r,
  output logic [COLOR_BITS-1:0]         vga_g,
  output logic [COLOR_BITS-1:0]         vga_b,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic [COORD_BITS-1:0]         sx,
  output logic [COORD_BITS-1:0]         sy,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underflow_cnt
);

  localparam int unsigned PW  = 3 * COLOR_BITS;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW = $clog2(HT);
  localparam int unsigned VCW = $clog2(VT);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_flush;
  logic   w_step;

  logic [PW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_under;

  logic [HCW-1:0] r_hc;
  logic [VCW-1:0] r_vc;
  logic [31:0]    w_hc32;
  logic [31:0]    w_vc32;
  logic           w_active;
  logic           w_hs_act;
  logic           w_vs_act;

  logic [PW-1:0]         r_rgb;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_de;
  logic [COORD_BITS-1:0] r_sx;
  logic [COORD_BITS-1:0] r_sy;
  logic                  r_frame_start;
  logic [15:0]           r_ucnt;

  // FIFO bookkeeping: pointers carry one extra bit so full and empty differ.
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_level == DEPTH_L);
  assign w_empty    = (w_level == '0);
  assign pix_ack    = rst && !w_full;
  assign fifo_level = w_level;

  // A flush drops any word offered on the same edge.
  assign w_push  = pix_stb && pix_ack && !w_flush;
  assign w_pop   = w_step && w_active && !w_empty;
  assign w_under = w_step && w_active && w_empty;

  // Raster decode on 32-bit copies so region bounds never overflow.
  assign w_hc32   = 32'(r_hc);
  assign w_vc32   = 32'(r_vc);
  assign w_active = (w_hc32 < H_ACTIVE) && (w_vc32 < V_ACTIVE);
  assign w_hs_act = (w_hc32 >= H_ACTIVE + H_FP) && (w_hc32 < H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_act = (w_vc32 >= V_ACTIVE + V_FP) && (w_vc32 < V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // w_step marks an edge that registers a raster pixel: every RUN edge, and
  // the PREFILL->RUN edge itself so (0,0) shows right after that edge.
  // Leaving for IDLE flushes only from an active state, so the FIFO can be
  // loaded while disabled.
  always_comb begin
    w_state_next = r_state;
    w_flush      = 1'b0;
    w_step       = 1'b0;
    if (!enable) begin
      w_state_next = ST_IDLE;
      w_flush      = (r_state != ST_IDLE);
    end else if (sync) begin
      w_state_next = ST_PREFILL;
      w_flush      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_PREFILL;
        ST_PREFILL: begin
          if (32'(w_level) >= PREFILL) begin
            w_state_next = ST_RUN;
            w_step       = 1'b1;
          end
        end
        ST_RUN:  w_step = 1'b1;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || !w_step) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_hc32 == HT - 1) begin
      r_hc <= '0;
      r_vc <= (w_vc32 == VT - 1) ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !w_step) begin
      r_rgb         <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_sx          <= COORD_BITS'(r_hc);
      r_sy          <= COORD_BITS'(r_vc);
      r_de          <= w_active;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_frame_start <= (r_hc == '0) && (r_vc == '0);
      if (!w_active)    r_rgb <= '0;
      else if (w_empty) r_rgb <= UNDERFLOW_COLOR;
      else              r_rgb <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                               r_ucnt <= '0;
    else if (w_under && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 1'b1;
  end

  assign vga_r         = r_rgb[PW-1 -: COLOR_BITS];
  assign vga_g         = r_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_b         = r_rgb[COLOR_BITS-1:0];
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign de            = r_de;
  assign sx            = r_sx;
  assign sy            = r_sy;
  assign frame_start   = r_frame_start;
  assign underflow_cnt = r_ucnt;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a small raster (14x7) and a 4-deep FIFO.
// The reference model tracks a linear raster position and a word queue.
module tb_vga_scanout;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int DEPTH = 4, PREF = 2;
  localparam logic [5:0] UFC = 6'h15;

  logic       clk = 1'b0;
  logic       rst = 1'b0, enable = 1'b0, sync = 1'b0, pix_stb = 1'b0;
  logic [5:0] pix_data = '0;
  logic       pix_ack;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync, de, frame_start;
  logic [9:0] sx, sy;
  logic [2:0] fifo_level;
  logic [15:0] underflow_cnt;

  vga_scanout #(
    .COLOR_BITS(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0),
    .COORD_BITS(10), .FIFO_DEPTH(DEPTH), .PREFILL(PREF), .UNDERFLOW_COLOR(UFC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync),
    .pix_data(pix_data), .pix_stb(pix_stb), .pix_ack(pix_ack),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .de(de), .sx(sx), .sy(sy),
    .frame_start(frame_start), .fifo_level(fifo_level),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  logic [5:0]  m_q[$];
  int          m_mode = 0;   // 0 idle, 1 prefill, 2 run
  int          m_pos  = 0;   // linear raster position of the next pixel
  logic [5:0]  e_rgb  = '0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_ack = 1'b0;
  logic [9:0]  e_sx = '0, e_sy = '0;
  logic [15:0] e_ucnt = '0;

  logic        cur_ack;
  logic [5:0]  src_buf [256];
  int          src_idx = 0;

  function automatic logic [49:0] dut_vec();
    return {vga_r, vga_g, vga_b, hsync, vsync, de, sx, sy, frame_start,
            fifo_level, underflow_cnt, cur_ack};
  endfunction

  function automatic logic [49:0] exp_vec();
    return {e_rgb, e_hs, e_vs, e_de, e_sx, e_sy, e_fs,
            3'(m_q.size()), e_ucnt, e_ack};
  endfunction

  task automatic model_blank();
    e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
    e_sx = '0; e_sy = '0; e_fs = 1'b0;
  endtask

  task automatic model_step(input logic r, e, s, st, input logic [5:0] d);
    bit push;
    bit act;
    int x, y;
    e_ack = r && (m_q.size() < DEPTH);
    push  = st && e_ack;
    if (!r) begin
      m_q.delete(); m_mode = 0; m_pos = 0; e_ucnt = '0; model_blank();
    end else if (!e) begin
      if (m_mode != 0) begin m_q.delete(); push = 1'b0; end
      m_mode = 0; m_pos = 0; model_blank();
    end else if (s) begin
      m_q.delete(); push = 1'b0; m_mode = 1; m_pos = 0; model_blank();
    end else if (m_mode == 0) begin
      m_mode = 1; model_blank();
    end else if (m_mode == 1 && m_q.size() < PREF) begin
      model_blank();
    end else begin
      m_mode = 2;
      x = m_pos % HT;
      y = m_pos / HT;
      act  = (x < HA) && (y < VA);
      e_sx = 10'(x);
      e_sy = 10'(y);
      e_de = act;
      e_hs = !((x >= HA + HF) && (x < HA + HF + HS));
      e_vs = !((y >= VA + VF) && (y < VA + VF + VS));
      e_fs = (m_pos == 0);
      if (!act) e_rgb = '0;
      else if (m_q.size() > 0) e_rgb = m_q.pop_front();
      else begin
        e_rgb = UFC;
        if (e_ucnt != 16'hFFFF) e_ucnt = e_ucnt + 16'd1;
      end
      m_pos = (m_pos + 1) % (HT * VT);
    end
    if (push) m_q.push_back(d);
  endtask

  // Drive one cycle's inputs after a falling edge, sample the live ready,
  // advance the model and return at the next falling edge.
  task automatic apply(input logic r, e, s, st);
    logic [5:0] d;
    d = src_buf[src_idx % 256];
    rst = r; enable = e; sync = s; pix_stb = st; pix_data = d;
    #1;
    cur_ack = pix_ack;
    model_step(r, e, s, st, d);
    if (st && cur_ack) src_idx++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL reset_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({vga_r, vga_g, vga_b, hsync, vsync, de, frame_start} !== {6'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_outs: got %b want %b", {vga_r, vga_g, vga_b, hsync, vsync, de, frame_start}, 10'b0000001100);
    end
    n_vec++;
    if ({sx, sy, fifo_level, underflow_cnt, pix_ack} !== '0) begin
      n_miss++;
      $display("FAIL reset_zero: got sx=%0d sy=%0d lvl=%0d ucnt=%0d ack=%b want all 0",
               sx, sy, fifo_level, underflow_cnt, pix_ack);
    end
  endtask

  task automatic test_timing();
    int de_cnt[7];
    int win0 = -1, last_fs = -1, n_fs = 0;
    for (int y = 0; y < 7; y++) de_cnt[y] = 0;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 230; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL timing_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (m_mode == 2) begin
        n_vec++;
        if (hsync !== !(sx >= 10 && sx <= 11) || vsync !== (sy != 5)) begin
          n_miss++;
          $display("FAIL timing_sync at (%0d,%0d): got hs=%b vs=%b", sx, sy, hsync, vsync);
        end
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_vec++;
          if (i - last_fs != 98) begin
            n_miss++;
            $display("FAIL timing_fs_period: got %0d want 98", i - last_fs);
          end
        end
        if (win0 < 0) win0 = i;
        last_fs = i;
        n_fs++;
      end
      if (win0 >= 0 && i < win0 + 98 && sy < 7 && de === 1'b1) de_cnt[sy]++;
    end
    for (int y = 0; y < 7; y++) begin
      n_vec++;
      if (de_cnt[y] != ((y < VA) ? HA : 0)) begin
        n_miss++;
        $display("FAIL timing_de_line %0d: got %0d want %0d", y, de_cnt[y], (y < VA) ? HA : 0);
      end
    end
    n_vec++;
    if (n_fs != 3) begin
      n_miss++;
      $display("FAIL timing_fs_count: got %0d want 3", n_fs);
    end
    n_vec++;
    if (underflow_cnt !== 16'd0) begin
      n_miss++;
      $display("FAIL timing_ucnt: got %0d want 0", underflow_cnt);
    end
  endtask

  task automatic test_data_order();
    logic [5:0] exp_rgb [3];
    int got = 0;
    exp_rgb[0] = {2'd3, 2'd3, 2'd3};
    exp_rgb[1] = {2'd0, 2'd0, 2'd1};
    exp_rgb[2] = {2'd2, 2'd2, 2'd2};
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    src_idx = 0;
    src_buf[0] = 6'h3F; src_buf[1] = 6'h01; src_buf[2] = 6'h2A;
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL order_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (de === 1'b1 && got < 3) begin
        n_vec++;
        if ({vga_r, vga_g, vga_b, sx, sy} !== {exp_rgb[got], 10'(got), 10'd0}) begin
          n_miss++;
          $display("FAIL order_pix %0d: got rgb=%0d/%0d/%0d at (%0d,%0d) want %h at (%0d,0)",
                   got, vga_r, vga_g, vga_b, sx, sy, exp_rgb[got], got);
        end
        got++;
      end
    end
    n_vec++;
    if (got != 3) begin
      n_miss++;
      $display("FAIL order_seen: got %0d pixels want 3", got);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      if (cur_ack === 1'b1) acc++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL bp_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (acc != 4 || fifo_level !== 3'd4 || pix_ack !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_full: got acc=%0d lvl=%0d ack=%b want 4/4/0", acc, fifo_level, pix_ack);
    end
  endtask

  task automatic test_underflow();
    int pushed = 0;
    logic st;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) begin
      st = (pushed < 5);
      apply(1'b1, 1'b1, 1'b0, st);
      if (st && cur_ack) pushed++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL uf_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (de === 1'b1 && sy == 0 && sx >= 5 && sx <= 7) begin
        n_vec++;
        if ({vga_r, vga_g, vga_b} !== UFC) begin
          n_miss++;
          $display("FAIL uf_color x=%0d: got %h want %h", sx, {vga_r, vga_g, vga_b}, UFC);
        end
      end
      if (m_mode == 2 && sx == 8 && sy < 4) begin
        n_vec++;
        if (underflow_cnt !== 16'(3 + 8 * sy)) begin
          n_miss++;
          $display("FAIL uf_count line %0d: got %0d want %0d", sy, underflow_cnt, 3 + 8 * sy);
        end
      end
    end
  endtask

  task automatic test_resync();
    bit found = 0;
    logic [5:0] first_word;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300 && !found; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL resync_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (m_mode == 2 && e_sx == 10'd5 && e_sy == 10'd2) found = 1;
    end
    if (!found) begin
      n_vec++; n_miss++;
      $display("FAIL resync_reach: got no (5,2) within 300 cycles want reached");
    end
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({de, sx, sy, fifo_level, frame_start} !== '0) begin
      n_miss++;
      $display("FAIL resync_blank: got de=%b sx=%0d sy=%0d lvl=%0d fs=%b want 0",
               de, sx, sy, fifo_level, frame_start);
    end
    first_word = src_buf[src_idx % 256];
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (frame_start !== 1'b0 || de !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL resync_prefill %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({frame_start, de, sx, sy, vga_r, vga_g, vga_b} !== {1'b1, 1'b1, 10'd0, 10'd0, first_word}) begin
      n_miss++;
      $display("FAIL resync_first: got fs=%b de=%b (%0d,%0d) rgb=%h want fs=1 de=1 (0,0) rgb=%h",
               frame_start, de, sx, sy, {vga_r, vga_g, vga_b}, first_word);
    end
  endtask

  task automatic test_reset_priority();
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL rprio_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    apply(1'b0, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({vga_r, vga_g, vga_b, hsync, vsync, de, sx, sy, frame_start, fifo_level, underflow_cnt, pix_ack}
        !== {6'd0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 3'd0, 16'd0, 1'b0}) begin
      n_miss++;
      $display("FAIL rprio_reset: got rgb=%h hs=%b vs=%b de=%b (%0d,%0d) fs=%b lvl=%0d ucnt=%0d ack=%b want reset values",
               {vga_r, vga_g, vga_b}, hsync, vsync, de, sx, sy, frame_start, fifo_level, underflow_cnt, pix_ack);
    end
  endtask

  task automatic test_random();
    logic r, e, s, st;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 99) < 97);
      s  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 9) < 7);
      apply(r, e, s, st);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL random_vec %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src_buf[i] = 6'($urandom);
    @(negedge clk);
    test_reset();
    test_timing();
    test_data_order();
    test_backpressure();
    test_underflow();
    test_resync();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
